irq_request_latch: RTL
======================

// Module: irq_request_latch
//
// PURPOSE
// Upstream companion of the 4-input priority encoder. Detects rising edges on
// four raw request lines and holds them as sticky pending bits under a mask.
// Drives the encoder's W input, takes back its index and zero flag, and runs a
// valid/ack handshake. Each acknowledged request clears exactly one pending bit.
//
// PARAMETERS
// ACK_TIMEOUT  8  cycles to wait for irq_ack before abandoning a grant;
//                 0 = no timeout (wait forever); legal range 0..255
//
// PORTS
// clk        in   1  system clock; all flops on rising edge
// rst_n      in   1  asynchronous, active-low reset
// req_in     in   4  raw request lines; a 0->1 transition is one event
// mask       in   4  per-line enable, 1 = line may be granted
// enc_w      out  4  pending & mask; drives encoder W
// enc_y      in   2  encoded index returned by encoder
// enc_zero   in   1  encoder zero flag (enc_w == 4'b0000)
// pending    out  4  raw sticky pending bits, unmasked
// irq_valid  out  1  grant outstanding
// irq_id     out  2  granted line index; stable while irq_valid=1
// irq_ack    in   1  consumer acknowledge of current grant
// timeout    out  1  one-cycle pulse when a grant is abandoned
//
// BEHAVIOUR
// - Reset (async assert, sync release):
//   - pending=0, irq_valid=0, irq_id=2'b00, timeout=0
//   - edge-history regs=0, wait counter=0, state=IDLE
//   - enc_w=0 follows combinationally.
//   - Reset asserted mid-handshake clears all state immediately; the grant is lost.
// - Edge detect: rise = req_s & ~req_d; req_d <= req_s each cycle.
//   - A rise sets the matching pending bit on the next clock edge.
//   - A level held high produces one event only.
// - enc_w = pending & mask, purely combinational.
// - enc_y is don't-care (may be X) while enc_zero=1 and is never sampled then.
// - FSM, 2 states:
//   - IDLE: if enc_zero=0, then irq_id<=enc_y, irq_valid<=1, cnt<=0 -> WAIT.
//     irq_ack is ignored in IDLE.
//   - WAIT, irq_ack=1: clear pending[irq_id], irq_valid<=0 -> IDLE.
//     The next grant appears no earlier than 2 cycles after the ack edge.
//   - WAIT, no ack, ACK_TIMEOUT!=0, cnt==ACK_TIMEOUT-1: irq_valid<=0,
//     timeout<=1 for one cycle, pending kept -> IDLE (re-grant follows).
//     Otherwise cnt<=cnt+1.
// - No preemption: higher-priority events or mask changes during WAIT do not
//   alter irq_id or irq_valid.
// - Set wins: a rise on line k in the same cycle that an ack clears
//   pending[k] leaves pending[k]=1.
// - irq_ack together with timeout expiry: the ack takes precedence, the
//   pending bit clears, and timeout stays 0.
// - cnt is 8 bits and never wraps: it is held in IDLE and reset on each grant.
//
// CONFIGURATION
// IRQ_SYNC_EN defined:
//   - req_in passes through a 2-flop synchronizer (reset to 0) before edge detect.
//   - Latency from req_in rise to pending bit set = 3 clock edges.
// IRQ_SYNC_EN undefined:
//   - req_s = req_in directly; latency = 1 clock edge.
//   - req_in must then be synchronous to clk.
//
// TESTING
// 1. Assert rst_n=0 mid-WAIT -> irq_valid, pending, enc_w, timeout all 0 with
//    no clock edge.
// 2. mask=4'hF, req_in 0000->0101, encoder attached -> pending=0101, irq_id=2'b10,
//    irq_valid=1. Ack -> pending=0001, then irq_id=2'b00 granted 2 cycles later.
// 3. mask=4'b1011, rise on req_in[2] -> pending=0100, enc_w=0000, no grant.
//    Set mask=4'hF -> grant with irq_id=2'b10.
// 4. ACK_TIMEOUT=4, never ack -> irq_valid high 4 cycles, timeout pulse 1 cycle,
//    pending unchanged, re-grant of same id.
// 5. Ack line 1 in the same cycle as a new rise on req_in[1] -> pending[1] stays 1,
//    line 1 re-granted.
// 6. Hold req_in[3]=1 across an ack -> pending[3] clears and is not re-set.
//    Run with and without IRQ_SYNC_EN: rise-to-pending latency is 3 and 1 edges.

Source files
------------

// File: rtl/irq_request_latch.sv
// irq_request_latch: edge-detected sticky IRQ pending bits with valid/ack grant handshake.
// Define IRQ_SYNC_EN to pass req_in through a 2-flop synchronizer before edge detection.
module irq_request_latch #(
    parameter int ACK_TIMEOUT = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req_in,
    input  logic [3:0] mask,
    output logic [3:0] enc_w,
    input  logic [1:0] enc_y,
    input  logic       enc_zero,
    output logic [3:0] pending,
    output logic       irq_valid,
    output logic [1:0] irq_id,
    input  logic       irq_ack,
    output logic       timeout
);
    typedef enum logic {S_IDLE, S_WAIT} state_t;

    localparam logic [7:0] LAST = 8'(ACK_TIMEOUT - 1);

    state_t     state_q, state_d;
    logic [3:0] req_s, req_d_q, rise, clr;
    logic [3:0] pending_q, pending_d;
    logic [1:0] irq_id_q, irq_id_d;
    logic [7:0] cnt_q, cnt_d;
    logic       timeout_q, timeout_d, expire;

`ifdef IRQ_SYNC_EN
    logic [3:0] sync1_q, sync2_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= req_in;
            sync2_q <= sync1_q;
        end
    end
    assign req_s = sync2_q;
`else
    assign req_s = req_in;
`endif

    assign rise      = req_s & ~req_d_q;
    assign enc_w     = pending_q & mask;
    assign pending   = pending_q;
    assign irq_valid = state_q == S_WAIT;
    assign irq_id    = irq_id_q;
    assign timeout   = timeout_q;
    assign expire    = (ACK_TIMEOUT != 0) && (cnt_q == LAST);

    // enc_y is only sampled when enc_zero=0, so an X there never reaches irq_id_q
    always_comb begin
        state_d   = state_q;
        irq_id_d  = irq_id_q;
        cnt_d     = cnt_q;
        timeout_d = 1'b0;
        clr       = 4'b0000;
        if (state_q == S_IDLE) begin
            if (!enc_zero) begin
                state_d  = S_WAIT;
                irq_id_d = enc_y;
                cnt_d    = 8'd0;
            end
        end else if (irq_ack) begin
            clr     = 4'b0001 << irq_id_q;
            state_d = S_IDLE;
        end else if (expire) begin
            state_d   = S_IDLE;
            timeout_d = 1'b1;
        end else begin
            cnt_d = cnt_q + {7'd0, cnt_q != 8'hFF};
        end
        pending_d = (pending_q & ~clr) | rise;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            req_d_q   <= '0;
            pending_q <= '0;
            irq_id_q  <= '0;
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            req_d_q   <= req_s;
            pending_q <= pending_d;
            irq_id_q  <= irq_id_d;
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end
endmodule
